dbg_step_display: RTL and testbench

DBG_STEP_DISPLAY -- requirements
Module: dbg_step_display

---
 rtl/dbg_step_display_pkg.sv | 10 +
 rtl/dbg_step_display_hex7seg.sv | 9 +
 rtl/dbg_step_display.sv | 88 ++++++++
 tb/tb_dbg_step_display.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_step_display_pkg.sv
// dbg_step_display_pkg: FSM state encoding and active-low hex segment table
package dbg_step_display_pkg;
  typedef enum logic [1:0] {ST_HALT = 2'd0, ST_RUN = 2'd1, ST_STEP = 2'd2} state_t;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/dbg_step_display_hex7seg.sv
// hex7seg: one hex nibble to active-low gfedcba segments
module hex7seg
  import dbg_step_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/dbg_step_display.sv
// dbg_step_display: run/halt/single-step CPU clock enable with PC/result hex display
module dbg_step_display
  import dbg_step_display_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DIGITS     = 6,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_run,
  input  logic                  step_btn,
  input  logic                  page,
  input  logic [31:0]           pc_in,
  input  logic [DATA_W-1:0]     result_in,
  output logic                  cpu_en,
  output logic [7*DIGITS-1:0]   seg,
  output logic [15:0]           step_count
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int DW  = $clog2(DEB_CYCLES + 1);
  localparam int WW  = 4 * (DIGITS - 2);
  logic [TW-1:0]     tcnt;
  logic              tick;
  logic              s1, s2, deb, deb_q, req;
  logic [DW-1:0]     dcnt;
  logic              dhit;
  state_t            state, nxt;
  logic              en_q;
  logic [7:0]        pc_snap;
  logic [DATA_W-1:0] res_snap;
  logic [2*WW-1:0]   res_pad;
  logic [WW-1:0]     win;
  logic              unused;
  assign unused = ^pc_in[31:8];
  assign tick   = tcnt == TW'(DIV - 1);
  assign dhit   = s2 != deb && dcnt == DW'(DEB_CYCLES - 1);
  assign req    = deb & ~deb_q;
  always_comb
    nxt = state == ST_HALT ? (mode_run ? ST_RUN : req ? ST_STEP : ST_HALT) :
          state == ST_RUN  ? (mode_run ? ST_RUN : ST_HALT) : ST_HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt       <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      deb        <= 1'b0;
      deb_q      <= 1'b0;
      dcnt       <= '0;
      state      <= ST_HALT;
      cpu_en     <= 1'b0;
      en_q       <= 1'b0;
      step_count <= '0;
      pc_snap    <= '0;
      res_snap   <= '0;
    end else begin
      tcnt       <= tick ? '0 : tcnt + 1'b1;
      s1         <= step_btn;
      s2         <= s1;
      deb_q      <= deb;
      dcnt       <= (s2 == deb || dhit) ? '0 : dcnt + 1'b1;
      deb        <= dhit ? s2 : deb;
      state      <= nxt;
      // the tick is honoured even if mode_run drops in the same cycle
      cpu_en     <= !cpu_en && ((state == ST_RUN && tick) || state == ST_STEP);
      en_q       <= cpu_en;
      step_count <= step_count + 16'(cpu_en);
      if (en_q) begin
        pc_snap  <= pc_in[7:0];
        res_snap <= result_in;
      end
    end
  end
  assign res_pad = (2*WW)'(res_snap);
  assign win     = page ? res_pad[2*WW-1:WW] : res_pad[WW-1:0];
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [3:0] nib;
    if (k < 2) begin : g_pc
      assign nib = pc_snap[7-4*k -: 4];
    end else begin : g_res
      assign nib = win[4*(DIGITS-1-k) +: 4];
    end
    hex7seg u_hex (.hex(nib), .seg(seg[7*k +: 7]));
  end
endmodule

// File: tb/tb_dbg_step_display.sv
// tb_dbg_step_display: randomized self-checking bench with a behavioural display/step model
module tb_dbg_step_display;
  localparam int CLK_HZ = 10;
  localparam int TICK_HZ = 1;
  localparam int DEB = 4;
  localparam int DIGITS = 6;
  localparam int DATA_W = 32;
  localparam int DIV = CLK_HZ / TICK_HZ;
  logic clk = 1'b0;
  logic rst, mode_run, step_btn, page;
  logic [31:0] pc_in;
  logic [DATA_W-1:0] result_in;
  logic cpu_en;
  logic [7*DIGITS-1:0] seg;
  logic [15:0] step_count;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int cyc = 0;
  int ptimes[$];
  logic [31:0] exp_pc = '0;
  logic [DATA_W-1:0] exp_res = '0;
  int exp_count = 0;

  dbg_step_display #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEB_CYCLES(DEB),
                     .DIGITS(DIGITS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .mode_run(mode_run), .step_btn(step_btn), .page(page),
    .pc_in(pc_in), .result_in(result_in), .cpu_en(cpu_en), .seg(seg),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cpu_en === 1'b1) begin
      pulses++;
      ptimes.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex_ref(input int v);
    case (v)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;  14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg(input logic [31:0] pc, input logic [DATA_W-1:0] res, input logic pg);
    logic [7*DIGITS-1:0] s;
    int nib, bp;
    s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = 0;
      if (k == 0) nib = int'(pc[7:4]);
      else if (k == 1) nib = int'(pc[3:0]);
      else begin
        bp = (pg ? 4 * (DIGITS - 2) : 0) + 4 * (DIGITS - 1 - k);
        for (int b = 0; b < 4; b++)
          if (bp + b < DATA_W) nib += int'(res[bp+b]) << b;
      end
      s[7*k +: 7] = hex_ref(nib);
    end
    return s;
  endfunction

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    step_btn = 1'b1;
    cyc_n(n);
    step_btn = 1'b0;
    cyc_n(15);
  endtask

  task automatic test_reset;
    int p0;
    rst = 1'b1; mode_run = 1'b0; step_btn = 1'b0; page = 1'b0; pc_in = '0; result_in = '0;
    cyc_n(3);
    checks++;
    if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
    rst = 1'b0;
    p0 = pulses;
    cyc_n(50);
    checks++;
    if (pulses != p0) begin failures++; $display("FAIL reset_idle_pulses got=%0d exp=0", pulses - p0); end
    checks++;
    if (step_count !== 16'h0) begin failures++; $display("FAIL reset_step_count got=%h exp=0000", step_count); end
    for (int k = 0; k < DIGITS; k++) begin
      checks++;
      if (seg[7*k +: 7] !== 7'b1000000) begin
        failures++; $display("FAIL reset_digit%0d got=%b exp=1000000", k, seg[7*k +: 7]);
      end
    end
  endtask

  task automatic test_run;
    int p0, q0, bad;
    pc_in = 32'h0000_00A4; result_in = 32'h1234_ABCD;
    p0 = pulses; q0 = ptimes.size();
    mode_run = 1'b1;
    cyc_n(100);
    mode_run = 1'b0;
    cyc_n(5);
    exp_count = (exp_count + 10) % 65536;
    exp_pc = pc_in; exp_res = result_in;
    checks++;
    if (pulses - p0 != 10) begin failures++; $display("FAIL run_pulse_count got=%0d exp=10", pulses - p0); end
    bad = 0;
    for (int i = q0 + 1; i < ptimes.size(); i++) if (ptimes[i] - ptimes[i-1] != DIV) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL run_pulse_spacing got=%0d bad_gaps exp=0", bad); end
    checks++;
    if (step_count !== 16'(exp_count)) begin failures++; $display("FAIL run_step_count got=%h exp=%h", step_count, 16'(exp_count)); end
    for (int pg = 0; pg < 2; pg++) begin
      page = pg[0];
      #1;
      checks++;
      if (seg !== exp_seg(exp_pc, exp_res, page)) begin
        failures++; $display("FAIL run_display_page%0d got=%h exp=%h", pg, seg, exp_seg(exp_pc, exp_res, page));
      end
    end
    // hand-derived digit A on digit 2 for page 0 independent of the model
    page = 1'b0;
    #1;
    checks++;
    if (seg[20:14] !== 7'b0001000) begin failures++; $display("FAIL run_digit2_A got=%b exp=0001000", seg[20:14]); end
  endtask

  task automatic test_snapshot_hold;
    pc_in = $urandom; result_in = $urandom;
    cyc_n(20);
    for (int pg = 0; pg < 2; pg++) begin
      page = pg[0];
      #1;
      checks++;
      if (seg !== exp_seg(exp_pc, exp_res, page)) begin
        failures++; $display("FAIL snapshot_hold_page%0d got=%h exp=%h", pg, seg, exp_seg(exp_pc, exp_res, page));
      end
    end
  endtask

  task automatic test_debounce;
    int p0;
    p0 = pulses;
    repeat (3) begin
      step_btn = 1'b1;
      cyc_n($urandom_range(1, DEB - 1));
      step_btn = 1'b0;
      cyc_n(10);
    end
    checks++;
    if (pulses != p0) begin failures++; $display("FAIL debounce_glitch got=%0d exp=0", pulses - p0); end
    pc_in = $urandom; result_in = $urandom;
    p0 = pulses;
    press(10);
    exp_count = (exp_count + 1) % 65536;
    exp_pc = pc_in; exp_res = result_in;
    checks++;
    if (pulses - p0 != 1) begin failures++; $display("FAIL debounce_step got=%0d exp=1", pulses - p0); end
    checks++;
    if (step_count !== 16'(exp_count)) begin failures++; $display("FAIL debounce_step_count got=%h exp=%h", step_count, 16'(exp_count)); end
    for (int pg = 0; pg < 2; pg++) begin
      page = pg[0];
      #1;
      checks++;
      if (seg !== exp_seg(exp_pc, exp_res, page)) begin
        failures++; $display("FAIL step_display_page%0d got=%h exp=%h", pg, seg, exp_seg(exp_pc, exp_res, page));
      end
    end
  endtask

  task automatic test_ignored;
    int p0, p1, i;
    pc_in = $urandom; result_in = $urandom;
    p0 = pulses;
    mode_run = 1'b1;
    step_btn = 1'b1;
    cyc_n(10);
    step_btn = 1'b0;
    cyc_n(50);
    mode_run = 1'b0;
    cyc_n(15);
    exp_count = (exp_count + 6) % 65536;
    exp_pc = pc_in; exp_res = result_in;
    checks++;
    if (pulses - p0 != 6) begin failures++; $display("FAIL ignored_req_pulses got=%0d exp=6", pulses - p0); end
    checks++;
    if (step_count !== 16'(exp_count)) begin failures++; $display("FAIL ignored_req_count got=%h exp=%h", step_count, 16'(exp_count)); end
    page = 1'b0;
    #1;
    checks++;
    if (seg !== exp_seg(exp_pc, exp_res, 1'b0)) begin
      failures++; $display("FAIL ignored_req_display got=%h exp=%h", seg, exp_seg(exp_pc, exp_res, 1'b0));
    end
    // drop mode_run exactly in the cycle of the next tick
    p0 = pulses;
    mode_run = 1'b1;
    for (i = 0; i < 30 && pulses == p0; i++) @(negedge clk);
    checks++;
    if (pulses == p0) begin failures++; $display("FAIL coincide_first_pulse got=0 exp=1 (timeout)"); end
    cyc_n(DIV - 1);
    mode_run = 1'b0;
    p1 = pulses;
    cyc_n(30);
    checks++;
    if (pulses - p1 != 1) begin failures++; $display("FAIL coincide_final_pulse got=%0d exp=1", pulses - p1); end
    exp_count = (exp_count + 2) % 65536;
    checks++;
    if (step_count !== 16'(exp_count)) begin failures++; $display("FAIL coincide_count got=%h exp=%h", step_count, 16'(exp_count)); end
    p0 = pulses;
    press(10);
    exp_count = (exp_count + 1) % 65536;
    checks++;
    if (pulses - p0 != 1) begin failures++; $display("FAIL coincide_halt_step got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.step_count = 16'hFFFE;
    @(negedge clk);
    release dut.step_count;
    exp_count = 16'hFFFE;
    press(10);
    exp_count = (exp_count + 1) % 65536;
    checks++;
    if (step_count !== 16'(exp_count)) begin failures++; $display("FAIL wrap_ffff got=%h exp=%h", step_count, 16'(exp_count)); end
    press(10);
    exp_count = (exp_count + 1) % 65536;
    checks++;
    if (step_count !== 16'(exp_count)) begin failures++; $display("FAIL wrap_zero got=%h exp=%h", step_count, 16'(exp_count)); end
  endtask

  task automatic test_mid_reset;
    int p0, i;
    step_btn = 1'b1;
    for (i = 0; i < 40 && dut.state != dbg_step_display_pkg::ST_STEP; i++) @(negedge clk);
    checks++;
    if (dut.state != dbg_step_display_pkg::ST_STEP) begin failures++; $display("FAIL mid_reset_step_entry got=timeout exp=STEP"); end
    rst = 1'b1;
    p0 = pulses;
    cyc_n(1);
    rst = 1'b0;
    step_btn = 1'b0;
    cyc_n(20);
    checks++;
    if (pulses != p0) begin failures++; $display("FAIL mid_reset_pulse got=%0d exp=0", pulses - p0); end
    checks++;
    if (step_count !== 16'h0) begin failures++; $display("FAIL mid_reset_count got=%h exp=0000", step_count); end
    checks++;
    if (seg !== exp_seg(32'h0, '0, page)) begin failures++; $display("FAIL mid_reset_display got=%h exp=%h", seg, exp_seg(32'h0, '0, page)); end
  endtask

  initial begin
    test_reset;
    test_run;
    test_snapshot_hold;
    test_debounce;
    test_ignored;
    test_wrap;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
